topdown_counter_bank: RTL



---
 rtl/topdown_monitor_pkg.sv | 23 ++
 rtl/topdown_sat_counter.sv | 54 +++++
 rtl/topdown_counter_bank.sv | 114 +++++++++++
 3 files changed

// File: rtl/topdown_monitor_pkg.sv
// Shared definitions for the top-down monitor and its counter bank:
// component/counter counts, counter index map and the read FSM state type.
package topdown_monitor_pkg;

  localparam int unsigned N_TOPDOWN_COMPS = 6;
  localparam int unsigned N_TOPDOWN_CNTS  = N_TOPDOWN_COMPS + 1;

  // Counter index map, shared by incr_i bit order, rd_idx_i and overflow_o.
  localparam logic [2:0] TD_IDX_BASE       = 3'd0;
  localparam logic [2:0] TD_IDX_ICACHE     = 3'd1;
  localparam logic [2:0] TD_IDX_BPRED      = 3'd2;
  localparam logic [2:0] TD_IDX_DCACHE     = 3'd3;
  localparam logic [2:0] TD_IDX_EXECUTE    = 3'd4;
  localparam logic [2:0] TD_IDX_DEPENDENCY = 3'd5;
  localparam logic [2:0] TD_IDX_CYCLES     = 3'd6;
  localparam logic [2:0] TD_IDX_ILLEGAL    = 3'd7;

  typedef enum logic [0:0] {
    TD_RD_IDLE,
    TD_RD_RESP
  } td_rd_state_e;

endpackage

// File: rtl/topdown_sat_counter.sv
// One saturating event counter with synchronous clear and sticky overflow.
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        zero count and overflow (wins over increment)
//   en_i, incr_i   count one when both are high
//   count_o        current count
//   overflow_o     set when an increment is suppressed at saturation
module topdown_sat_counter #(
  parameter int unsigned Width   = 48,
  // Saturation point is 2**SatBits-1; a smaller value gives a bound-reduced build.
  parameter int unsigned SatBits = Width
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             incr_i,
  output logic [Width-1:0] count_o,
  output logic             overflow_o
);

  localparam logic [Width-1:0] MaxVal = {Width{1'b1}} >> (Width - SatBits);

  logic [Width-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (en_i && incr_i) begin
      if (count_q == MaxVal) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + Width'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/topdown_counter_bank.sv
// Top-down counter bank: six component counters plus an enabled-cycle counter,
// an atomic snapshot of all seven, and a request/valid read port on the snapshot.
//   clk_i, rst_i        clock, synchronous active-high reset
//   incr_i              per-component increment pulses
//   count_en_i          global count enable
//   clear_i             zero live counters and overflow flags
//   snapshot_i          copy live counters (pre-edge values) into snapshots
//   rd_req_i/idx/hi     read request, counter index, upper-word select
//   rd_ready_o          read port idle
//   rd_valid_o          one-cycle response strobe
//   rd_data_o/rd_err_o  response word / illegal-index flag, held until next request
//   overflow_o          sticky saturation flags
module topdown_counter_bank
  import topdown_monitor_pkg::*;
#(
  parameter int unsigned CounterWidth = 48,
  parameter int unsigned ReadWidth    = 32,
  parameter int unsigned SatBits      = CounterWidth
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_TOPDOWN_COMPS-1:0] incr_i,
  input  logic                      count_en_i,
  input  logic                      clear_i,
  input  logic                      snapshot_i,
  input  logic                      rd_req_i,
  input  logic [2:0]                rd_idx_i,
  input  logic                      rd_hi_i,
  output logic                      rd_ready_o,
  output logic                      rd_valid_o,
  output logic [ReadWidth-1:0]      rd_data_o,
  output logic                      rd_err_o,
  output logic [N_TOPDOWN_CNTS-1:0] overflow_o
);

  logic [CounterWidth-1:0]   live   [N_TOPDOWN_CNTS];
  logic [CounterWidth-1:0]   snap_q [N_TOPDOWN_CNTS];
  logic [N_TOPDOWN_CNTS-1:0] cnt_incr;

  // The cycle counter sees a constant increment; count_en_i gates it.
  assign cnt_incr = {1'b1, incr_i};

  for (genvar k = 0; k < N_TOPDOWN_CNTS; k++) begin : g_cnt
    topdown_sat_counter #(
      .Width   (CounterWidth),
      .SatBits (SatBits)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .en_i       (count_en_i),
      .incr_i     (cnt_incr[k]),
      .count_o    (live[k]),
      .overflow_o (overflow_o[k])
    );
  end

  // Samples pre-edge live values, so snapshot+clear is a read-and-reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_TOPDOWN_CNTS; k++) snap_q[k] <= '0;
    end else if (snapshot_i) begin
      for (int k = 0; k < N_TOPDOWN_CNTS; k++) snap_q[k] <= live[k];
    end
  end

  logic [CounterWidth-1:0] sel_cnt;
  logic [ReadWidth-1:0]    sel_word;
  logic                    sel_err;

  always_comb begin
    sel_cnt  = '0;
    sel_word = '0;
    sel_err  = 1'b0;
    if (rd_idx_i == TD_IDX_ILLEGAL) begin
      sel_err = 1'b1;
    end else begin
      sel_cnt = snap_q[rd_idx_i];
      if (rd_hi_i) sel_word = ReadWidth'(sel_cnt[CounterWidth-1:32]);
      else         sel_word = ReadWidth'(sel_cnt[31:0]);
    end
  end

  td_rd_state_e         state_q;
  logic [ReadWidth-1:0] rd_data_q;
  logic                 rd_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= TD_RD_IDLE;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      case (state_q)
        TD_RD_IDLE: begin
          if (rd_req_i) begin
            rd_data_q <= sel_word;
            rd_err_q  <= sel_err;
            state_q   <= TD_RD_RESP;
          end
        end
        // Requests arriving here are dropped.
        TD_RD_RESP: state_q <= TD_RD_IDLE;
        default:    state_q <= TD_RD_IDLE;
      endcase
    end
  end

  assign rd_ready_o = (state_q == TD_RD_IDLE);
  assign rd_valid_o = (state_q == TD_RD_RESP);
  assign rd_data_o  = rd_data_q;
  assign rd_err_o   = rd_err_q;

endmodule
